// File: rtl/apb_event_queue_pkg.sv
// Register map and bit positions for the APB event queue.
// Shared by the top level and the testbench-facing decode.
package apb_event_queue_pkg;

  localparam logic [7:0] POP_OFF    = 8'h00;
  localparam logic [7:0] STATUS_OFF = 8'h04;
  localparam logic [7:0] CTRL_OFF   = 8'h08;
  localparam logic [7:0] MASK_BASE  = 8'h10;

  localparam int STAT_OVF_BIT = 16;
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_THR_LSB = 8;
  localparam logic [7:0] THRESH_RST = 8'd1;

  function automatic int mask_words(int n);
    return (n + 31) / 32;
  endfunction

endpackage

// File: rtl/evq_fifo.sv
// Synchronous FIFO of event IDs.
// Push is refused when full, pop is refused when empty.
module evq_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_o <= count_o + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/apb_event_queue.sv
// APB event queue: latches uDMA event pulses, drains lowest ID
// first into a FIFO that software pops over APB.
module apb_event_queue
  import apb_event_queue_pkg::*;
#(
  parameter int NUM_EVENTS     = 132,
  parameter int FIFO_DEPTH     = 16,
  parameter int APB_ADDR_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_EVENTS-1:0]     events_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      irq_o
);

  localparam int ID_W = $clog2(NUM_EVENTS);
  localparam int NW   = mask_words(NUM_EVENTS);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0] MASK_END = MASK_BASE + 8'(4 * NW);

  logic [NUM_EVENTS-1:0] pend;
  logic [NUM_EVENTS-1:0] mask;
  logic [NUM_EVENTS-1:0] mask_wr;
  logic [NUM_EVENTS-1:0] arrive;
  logic [NUM_EVENTS-1:0] grant;
  logic [NW*32-1:0]      mask_pad;
  logic [31:0]           mask_rd;
  logic [ID_W-1:0]       gnt_idx;
  logic [ID_W-1:0]       fifo_dout;
  logic [CW-1:0]         count;
  logic [7:0]            thresh;
  logic [7:0]            thr_eff;
  logic [7:0]            off;
  logic [5:0]            widx;
  logic [31:0]           rdata;
  logic                  en;
  logic                  ovf;
  logic                  ovf_set;
  logic                  ovf_clr;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  acc;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  hit_pop;
  logic                  hit_stat;
  logic                  hit_ctrl;
  logic                  hit_mask;
  logic                  err;
  logic                  unused_addr;

  assign unused_addr = ^paddr_i[APB_ADDR_WIDTH-1:8];

  assign acc    = psel_i & penable_i;
  assign rd_acc = acc & ~pwrite_i;
  assign wr_acc = acc & pwrite_i;
  assign off    = paddr_i[7:0];
  assign widx   = 6'((off - MASK_BASE) >> 2);

  assign hit_pop  = (off == POP_OFF);
  assign hit_stat = (off == STATUS_OFF);
  assign hit_ctrl = (off == CTRL_OFF);
  assign hit_mask = (off >= MASK_BASE) && (off < MASK_END)
                  && (off[1:0] == 2'b00);

  // Lowest pending index wins
  always_comb begin
    gnt_idx = '0;
    for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
      if (pend[i]) gnt_idx = ID_W'(i);
    end
  end

  assign push    = (|pend) & ~full;
  assign grant   = push ? (NUM_EVENTS'(1) << gnt_idx) : '0;
  assign arrive  = events_i & mask & {NUM_EVENTS{en}};
  assign ovf_set = |(arrive & pend & ~grant);
  assign ovf_clr = wr_acc & hit_stat & pwdata_i[STAT_OVF_BIT];
  assign pop     = rd_acc & hit_pop & ~empty;

  always_comb begin
    mask_pad = '0;
    mask_pad[NUM_EVENTS-1:0] = mask;
  end

  assign mask_rd = mask_pad[widx*32 +: 32];

  always_comb begin
    mask_wr = mask;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if ((i / 32) == int'(widx)) mask_wr[i] = pwdata_i[i%32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend   <= '0;
      mask   <= '1;
      ovf    <= 1'b0;
      en     <= 1'b0;
      thresh <= THRESH_RST;
    end else begin
      pend <= (pend & ~grant) | arrive;
      ovf  <= (ovf & ~ovf_clr) | ovf_set;
      if (wr_acc & hit_ctrl) begin
        en     <= pwdata_i[CTRL_EN_BIT];
        thresh <= pwdata_i[CTRL_THR_LSB +: 8];
      end
      if (wr_acc & hit_mask) mask <= mask_wr;
    end
  end

  evq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ID_W),
    .CW    (CW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (gnt_idx),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    rdata = '0;
    err   = 1'b0;
    unique case (1'b1)
      hit_pop: begin
        if (!empty) begin
          rdata[31]         = 1'b1;
          rdata[ID_W-1:0]   = fifo_dout;
        end
      end
      hit_stat: begin
        rdata[STAT_OVF_BIT] = ovf;
        rdata[7:0]          = 8'(count);
      end
      hit_ctrl: begin
        rdata[CTRL_THR_LSB +: 8] = thresh;
        rdata[CTRL_EN_BIT]       = en;
      end
      hit_mask: rdata = mask_rd;
      default:  err = 1'b1;
    endcase
  end

  assign prdata_o  = (rd_acc & ~err) ? rdata : '0;
  assign pslverr_o = acc & err;
  assign pready_o  = 1'b1;

  assign thr_eff = (thresh == 8'd0) ? 8'd1 : thresh;
  assign irq_o   = en & (8'(count) >= thr_eff);

endmodule

// File: tb/tb_apb_event_queue.sv
// Directed and randomized bench for apb_event_queue against a
// queue-based reference model.
module tb_apb_event_queue;

  localparam int NE    = 132;
  localparam int DEPTH = 16;
  localparam int NW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NE-1:0] events;
  logic [31:0]   paddr;
  logic [31:0]   pwdata;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;
  logic          irq;

  always #5 clk = ~clk;

  apb_event_queue #(
    .NUM_EVENTS     (NE),
    .FIFO_DEPTH     (DEPTH),
    .APB_ADDR_WIDTH (32)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .events_i  (events),
    .paddr_i   (paddr),
    .pwdata_i  (pwdata),
    .pwrite_i  (pwrite),
    .psel_i    (psel),
    .penable_i (penable),
    .prdata_o  (prdata),
    .pready_o  (pready),
    .pslverr_o (pslverr),
    .irq_o     (irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model
  bit m_pend[NE];
  bit m_mask[NE];
  int q[$];
  bit m_ovf;
  bit m_en;
  int m_thr;

  function automatic void m_reset();
    for (int i = 0; i < NE; i++) begin
      m_pend[i] = 1'b0;
      m_mask[i] = 1'b1;
    end
    q.delete();
    m_ovf = 1'b0;
    m_en  = 1'b0;
    m_thr = 1;
  endfunction

  function automatic bit is_mask(int off);
    return off >= 16 && off < 16 + 4 * NW && off % 4 == 0;
  endfunction

  function automatic bit mapped(int off);
    return off == 0 || off == 4 || off == 8 || is_mask(off);
  endfunction

  function automatic logic [31:0] m_read(int off);
    logic [31:0] v;
    v = '0;
    if (off == 0) begin
      if (q.size() > 0) v = 32'h8000_0000 | 32'(q[0]);
    end else if (off == 4) begin
      v = (32'(m_ovf) << 16) | 32'(q.size());
    end else if (off == 8) begin
      v = (32'(m_thr) << 8) | 32'(m_en);
    end else if (is_mask(off)) begin
      for (int j = 0; j < 32; j++) begin
        int idx;
        idx = (off - 16) / 4 * 32 + j;
        if (idx < NE && m_mask[idx]) v[j] = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic bit m_irq();
    int t;
    t = (m_thr == 0) ? 1 : m_thr;
    return m_en && q.size() >= t;
  endfunction

  function automatic void m_step(bit ac, bit wr, int off,
                                 logic [31:0] wd,
                                 logic [NE-1:0] ev);
    int  g;
    int  sz;
    bit  pop_ok;
    bit  oset;
    bit  arr[NE];
    g    = -1;
    oset = 1'b0;
    sz   = q.size();
    if (sz < DEPTH) begin
      for (int i = 0; i < NE; i++) begin
        if (m_pend[i]) begin
          g = i;
          break;
        end
      end
    end
    pop_ok = ac && !wr && off == 0 && sz > 0;
    for (int i = 0; i < NE; i++) begin
      arr[i] = ev[i] && m_mask[i] && m_en;
      if (arr[i] && m_pend[i] && i != g) oset = 1'b1;
    end
    for (int i = 0; i < NE; i++)
      m_pend[i] = (m_pend[i] && i != g) || arr[i];
    if (pop_ok) void'(q.pop_front());
    if (g >= 0) q.push_back(g);
    m_ovf = (m_ovf && !(ac && wr && off == 4 && wd[16])) || oset;
    if (ac && wr && off == 8) begin
      m_en  = wd[0];
      m_thr = int'(wd[15:8]);
    end
    if (ac && wr && is_mask(off)) begin
      for (int j = 0; j < 32; j++) begin
        int idx;
        idx = (off - 16) / 4 * 32 + j;
        if (idx < NE) m_mask[idx] = wd[j];
      end
    end
  endfunction

  logic [31:0] last_rd;
  logic        last_err;

  task automatic step(input bit rs, input logic [NE-1:0] ev,
                      input bit ac, input bit wr, input int off,
                      input logic [31:0] wd);
    logic [31:0] exp_rd;
    rst     = rs;
    events  = ev;
    psel    = ac;
    penable = ac;
    pwrite  = wr;
    paddr   = ($urandom() & 32'hFFFF_FF00) | 32'(off);
    pwdata  = wd;
    #1;
    exp_rd = (ac && !wr) ? m_read(off) : 32'h0;
    chk("prdata", prdata, exp_rd);
    chk("pslverr", 32'(pslverr), 32'(ac && !mapped(off)));
    chk("irq", 32'(irq), 32'(m_irq()));
    chk("pready", 32'(pready), 32'h1);
    last_rd  = prdata;
    last_err = pslverr;
    @(posedge clk);
    if (rs) m_reset();
    else    m_step(ac, wr, off, wd, ev);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic rd(input int off);
    step(1'b0, '0, 1'b1, 1'b0, off, 32'h0);
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    step(1'b0, '0, 1'b1, 1'b1, off, d);
  endtask

  task automatic pulse(input logic [NE-1:0] ev);
    step(1'b0, ev, 1'b0, 1'b0, 0, 32'h0);
  endtask

  initial begin
    logic [NE-1:0] e;
    rst     = 1'b1;
    events  = '0;
    paddr   = '0;
    pwdata  = '0;
    pwrite  = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_reset();

    // Reset state
    rd(8);
    chk("ctrl_rst", last_rd, 32'h0000_0100);
    rd(0);
    chk("pop_rst", last_rd, 32'h0);
    chk("irq_rst", 32'(irq), 32'h0);

    // Single event latency
    wr(8, 32'h0000_0101);
    e = '0; e[37] = 1'b1;
    pulse(e);
    chk("irq_n1", 32'(irq), 32'h0);
    idle();
    chk("irq_n2", 32'(irq), 32'h1);
    rd(0);
    chk("pop37", last_rd, 32'h8000_0025);
    rd(0);
    chk("pop_empty", last_rd, 32'h0);
    chk("irq_drained", 32'(irq), 32'h0);

    // Simultaneous events drain ascending
    e = '0; e[3] = 1'b1; e[130] = 1'b1; e[64] = 1'b1;
    pulse(e);
    repeat (3) idle();
    rd(4);
    chk("count3", last_rd, 32'h3);
    rd(0); chk("pop3", last_rd, 32'h8000_0003);
    rd(0); chk("pop64", last_rd, 32'h8000_0040);
    rd(0); chk("pop130", last_rd, 32'h8000_0082);

    // Fill, overflow and drain
    e = '0;
    for (int i = 16; i < 32; i++) e[i] = 1'b1;
    pulse(e);
    repeat (16) idle();
    e = '0; e[5] = 1'b1;
    pulse(e);
    pulse(e);
    rd(4);
    chk("full_ovf", last_rd, 32'h0001_0010);
    for (int i = 0; i < 16; i++) begin
      rd(0);
      chk("pop_fill", last_rd, 32'h8000_0000 | 32'(16 + i));
    end
    rd(0);
    chk("pop17", last_rd, 32'h8000_0005);
    wr(4, 32'h0001_0000);
    rd(4);
    chk("ovf_clr", last_rd, 32'h0);

    // Mask and threshold
    wr(16, 32'hFFFF_FFFE);
    e = '0; e[0] = 1'b1;
    pulse(e);
    idle(); idle();
    rd(4);
    chk("masked", last_rd, 32'h0);
    wr(8, 32'h0000_0401);
    e = '0; e[1] = 1'b1; e[2] = 1'b1; e[3] = 1'b1;
    pulse(e);
    repeat (3) idle();
    chk("thr_below", 32'(irq), 32'h0);
    e = '0; e[7] = 1'b1;
    pulse(e);
    idle();
    chk("thr_hit", 32'(irq), 32'h1);

    // Unmapped access and mid-run reset
    rd(12);
    chk("err_0c", 32'(last_err), 32'h1);
    chk("err_rd", last_rd, 32'h0);
    e = '0; e[9] = 1'b1;
    pulse(e);
    idle();
    rd(4);
    chk("count5", last_rd, 32'h5);
    step(1'b1, '0, 1'b0, 1'b0, 0, 32'h0);
    chk("irq_after_rst", 32'(irq), 32'h0);
    rd(4);
    chk("count_after_rst", last_rd, 32'h0);

    // Randomized traffic
    wr(8, 32'h0000_0101);
    for (int c = 0; c < 3000; c++) begin
      bit          rs;
      bit          ac;
      bit          w;
      int          off;
      int          sel;
      logic [31:0] wd;
      rs = ($urandom_range(0, 599) == 0);
      e  = '0;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) e[$urandom_range(0, NE - 1)] = 1'b1;
      end
      ac  = $urandom_range(0, 1) == 1;
      w   = 1'b0;
      off = 0;
      wd  = $urandom();
      sel = $urandom_range(0, 9);
      if (sel <= 4) begin
        off = 0;
      end else if (sel == 5) begin
        off = 4;
        w   = $urandom_range(0, 1) == 1;
      end else if (sel == 6) begin
        off = 8;
        w   = $urandom_range(0, 2) == 0;
        wd  = (32'($urandom_range(0, 20)) << 8)
            | 32'($urandom_range(0, 6) != 0);
      end else if (sel == 7) begin
        off = 16 + 4 * $urandom_range(0, NW - 1);
        w   = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 3) != 0) wd = 32'hFFFF_FFFF;
      end else if (sel == 8) begin
        case ($urandom_range(0, 4))
          0: off = 12;
          1: off = 36;
          2: off = 40;
          3: off = 68;
          default: off = 2;
        endcase
        w = $urandom_range(0, 1) == 1;
      end else begin
        off = 0;
        w   = 1'b1;
      end
      step(rs, e, ac, w, off, wd);
      if (rs) wr(8, 32'h0000_0101);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
